// File: rtl/count_event_monitor_pkg.sv
// Shared definitions for the count event monitor: event kinds, FSM states and
// the layout of a queued event record {kind, count, time}.
package count_event_monitor_pkg;

  localparam int KindW = 2;

  localparam logic [KindW-1:0] KIND_NONE  = 2'b00;
  localparam logic [KindW-1:0] KIND_WRAP  = 2'b01;
  localparam logic [KindW-1:0] KIND_JUMP  = 2'b10;
  localparam logic [KindW-1:0] KIND_FIRST = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_TRACK = 1'b1
  } mon_state_e;

  function automatic int rec_width(input int size, input int ts_width);
    return KindW + size + ts_width;
  endfunction

endpackage

// File: rtl/count_event_fifo.sv
// Synchronous event FIFO; a push while full is still taken if a pop retires
// the head in the same cycle. Output reads zero when empty.
module count_event_fifo #(
  parameter int W     = 8,
  parameter int Depth = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(Depth);
  localparam logic [AW:0] FullCnt = (AW+1)'(Depth);

  logic [W-1:0]  mem [Depth];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FullCnt);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: contents are only visible while non-empty.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/count_event_monitor.sv
// Watches an upstream counter, classifies each sampled step and queues
// FIRST/WRAP/JUMP events with a timestamp for a valid/ready consumer.
module count_event_monitor
  import count_event_monitor_pkg::*;
#(
  parameter int Size    = 5,
  parameter int TsWidth = 16,
  parameter int Depth   = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [Size-1:0]    count_in,
  input  logic               sample_en,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [1:0]         evt_kind,
  output logic [Size-1:0]    evt_count,
  output logic [TsWidth-1:0] evt_time,
  output logic               overflow,
  output logic [7:0]         drop_count
);

  localparam int RecW = rec_width(Size, TsWidth);
  localparam logic [Size-1:0] CntMax = '1;

  mon_state_e         state, state_n;
  logic [Size-1:0]    prev, prev_inc;
  logic [TsWidth-1:0] ts;
  logic               push, fifo_full, fifo_empty, drop;
  logic [KindW-1:0]   kind;
  logic [RecW-1:0]    rd_rec;

  assign prev_inc = prev + 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      prev  <= '0;
      ts    <= '0;
    end else begin
      state <= state_n;
      ts    <= ts + 1'b1;
      if (sample_en) prev <= count_in;
    end
  end

  // Wrap is tested before step: at prev==max, prev_inc is also 0.
  always_comb begin
    state_n = state;
    push    = 1'b0;
    kind    = KIND_NONE;
    if (sample_en) begin
      if (state == ST_IDLE) begin
        push    = 1'b1;
        kind    = KIND_FIRST;
        state_n = ST_TRACK;
      end else if (prev == CntMax && count_in == '0) begin
        push = 1'b1;
        kind = KIND_WRAP;
      end else if (count_in != prev && count_in != prev_inc) begin
        push = 1'b1;
        kind = KIND_JUMP;
      end
    end
  end

  count_event_fifo #(.W(RecW), .Depth(Depth)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .wr_data ({kind, count_in, ts}),
    .pop     (evt_ready),
    .rd_data (rd_rec),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign evt_valid = !fifo_empty;
  assign {evt_kind, evt_count, evt_time} = rd_rec;
  assign drop = push && fifo_full && !(evt_valid && evt_ready);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_count_event_monitor.sv
// Directed bench for count_event_monitor: stimulus queues expected events,
// an independent monitor pops and compares on each accepted handshake.
module tb_count_event_monitor;

  localparam logic [1:0] K_WRAP = 2'b01, K_JUMP = 2'b10, K_FIRST = 2'b11;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  count_in = '0;
  logic        sample_en = 1'b0;
  logic        evt_valid, evt_ready = 1'b0;
  logic [1:0]  evt_kind;
  logic [4:0]  evt_count;
  logic [15:0] evt_time;
  logic        overflow;
  logic [7:0]  drop_count;

  logic [15:0] tb_ts;
  logic [22:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  count_event_monitor #(.Size(5), .TsWidth(16), .Depth(4)) dut (
    .clock(clock), .reset(reset), .count_in(count_in), .sample_en(sample_en),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_kind(evt_kind),
    .evt_count(evt_count), .evt_time(evt_time), .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  // Reference timestamp: the value the design should hold in the current cycle.
  always @(posedge clock or negedge reset) begin
    if (!reset) tb_ts <= '0;
    else        tb_ts <= tb_ts + 16'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic smp(input logic [4:0] c, input logic ev, input logic [1:0] k);
    sample_en = 1'b1;
    count_in  = c;
    if (ev) exp_q.push_back({k, c, tb_ts});
    step();
    sample_en = 1'b0;
  endtask

  task automatic rst_pulse();
    reset = 1'b0;
    exp_q.delete();
    #2;
    reset = 1'b1;
    step();
  endtask

  // Monitor: compare the head event on every accepted handshake.
  initial begin
    logic [22:0] e;
    forever begin
      @(negedge clock);
      if (reset && evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_event: got kind=%0d count=%0d time=%0d expected none",
                   evt_kind, evt_count, evt_time);
        end else begin
          e = exp_q.pop_front();
          n_vec++;
          if ({evt_kind, evt_count, evt_time} !== e) begin
            n_err++;
            $display("FAIL event: got kind=%0d count=%0d time=%0d expected kind=%0d count=%0d time=%0d",
                     evt_kind, evt_count, evt_time, e[22:21], e[20:16], e[15:0]);
          end
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) step();
    chk("rst_valid", evt_valid, 0);
    chk("rst_kind", evt_kind, 0);
    chk("rst_count", evt_count, 0);
    chk("rst_time", evt_time, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drops", drop_count, 0);

    // 1: first sample at timestamp 3
    reset = 1'b1;
    evt_ready = 1'b1;
    repeat (3) step();
    sample_en = 1'b1;
    count_in  = 5'd0;
    exp_q.push_back({K_FIRST, 5'd0, 16'd3});
    step();
    sample_en = 1'b0;
    chk("t1_latency", evt_valid, 1);
    repeat (2) step();
    chk("t1_drained", exp_q.size(), 0);

    // 2: full count run with one wrap
    rst_pulse();
    smp(5'd0, 1'b1, K_FIRST);
    for (int i = 1; i < 32; i++) smp(5'(i), 1'b0, 2'b00);
    smp(5'd0, 1'b1, K_WRAP);
    repeat (3) step();
    chk("t2_drained", exp_q.size(), 0);

    // 3: upstream reset and injected jump, then a hold
    for (int i = 1; i <= 5; i++) smp(5'(i), 1'b0, 2'b00);
    smp(5'd0, 1'b1, K_JUMP);
    for (int i = 1; i <= 5; i++) smp(5'(i), 1'b0, 2'b00);
    smp(5'd9, 1'b1, K_JUMP);
    smp(5'd9, 1'b0, 2'b00);
    repeat (3) step();
    chk("t3_drained", exp_q.size(), 0);

    // 5: push while full with a simultaneous pop
    evt_ready = 1'b0;
    smp(5'd12, 1'b1, K_JUMP);
    smp(5'd20, 1'b1, K_JUMP);
    smp(5'd3,  1'b1, K_JUMP);
    smp(5'd25, 1'b1, K_JUMP);
    chk("t5_head_held", evt_count, 12);
    evt_ready = 1'b1;
    smp(5'd30, 1'b1, K_JUMP);
    evt_ready = 1'b0;
    chk("t5_overflow", overflow, 0);
    chk("t5_drops", drop_count, 0);
    smp(5'd2, 1'b0, 2'b00);  // still full: this one must drop
    chk("t5_occupancy_probe", drop_count, 1);
    evt_ready = 1'b1;
    repeat (6) step();
    chk("t5_drained", exp_q.size(), 0);

    // 4: overflow with stalled consumer, then in-order drain
    evt_ready = 1'b0;
    rst_pulse();
    smp(5'd0,  1'b1, K_FIRST);
    smp(5'd10, 1'b1, K_JUMP);
    smp(5'd20, 1'b1, K_JUMP);
    smp(5'd7,  1'b1, K_JUMP);
    chk("t4_stall_kind", evt_kind, K_FIRST);
    smp(5'd15, 1'b0, 2'b00);
    chk("t4_overflow", overflow, 1);
    chk("t4_drops", drop_count, 1);
    chk("t4_head_kept", {evt_kind, evt_count}, {K_FIRST, 5'd0});
    evt_ready = 1'b1;
    repeat (4) step();
    chk("t4_empty_valid", evt_valid, 0);
    chk("t4_empty_fields", {evt_kind, evt_count, evt_time}, 0);
    chk("t4_drained", exp_q.size(), 0);

    // 6: asynchronous reset with events queued
    evt_ready = 1'b0;
    rst_pulse();
    smp(5'd4, 1'b1, K_FIRST);
    smp(5'd8, 1'b1, K_JUMP);
    smp(5'd1, 1'b1, K_JUMP);
    chk("t6_queued", evt_valid, 1);
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_async_valid", evt_valid, 0);
    chk("t6_overflow_clr", overflow, 0);
    #1;
    reset = 1'b1;
    step();
    evt_ready = 1'b1;
    smp(5'd6, 1'b1, K_FIRST);
    repeat (3) step();
    chk("t6_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
